// File: rtl/sdadc_pkg.sv
// Shared types and constants for the sigma-delta ADC sample arbiter.
package sdadc_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } ch_state_t;

    localparam int SETTLE_CNT_W = 8;

endpackage

// File: rtl/sdadc_ch_ctrl.sv
// Per-channel control: power/reset sequencing, settle discard, one-deep sample
// holding register and sticky overrun flag.
module sdadc_ch_ctrl
    import sdadc_pkg::*;
#(
    parameter int ADC_BITLEN     = 16,
    parameter int SETTLE_SAMPLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  adc_valid,
    input  logic [ADC_BITLEN-1:0] adc_data,
    input  logic                  grant,
    input  logic                  overrun_clr,
    output logic                  adc_rst,
    output logic                  pending,
    output logic [ADC_BITLEN-1:0] hold_data,
    output logic                  overrun
);

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_TARGET = SETTLE_CNT_W'(SETTLE_SAMPLES);

    ch_state_t               state, state_next;
    logic [SETTLE_CNT_W-1:0] cnt, cnt_next;
    logic                    capture;

    // A grant is only ever issued while enabled, so capture needs no grant term.
    assign capture = (state == RUN) && enable && adc_valid;
    assign adc_rst = (state == OFF);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next = state;
        cnt_next   = cnt;
        case (state)
            OFF: begin
                if (enable) begin
                    cnt_next   = '0;
                    state_next = (SETTLE_SAMPLES == 0) ? RUN : SETTLE;
                end
            end
            SETTLE: begin
                if (!enable) begin
                    state_next = OFF;
                end else if (adc_valid) begin
                    cnt_next = cnt + SETTLE_CNT_W'(1);
                    if (cnt_next == SETTLE_TARGET) state_next = RUN;
                end
            end
            RUN: begin
                if (!enable) state_next = OFF;
            end
            default: state_next = OFF;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= OFF;
            cnt     <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;

            if (capture)                pending <= 1'b1;
            else if (grant || !enable)  pending <= 1'b0;

            if (capture && pending && !grant) overrun <= 1'b1;
            else if (overrun_clr)             overrun <= 1'b0;
        end
    end

    // NOTE: sample data needs no reset; it is qualified by pending everywhere it is used.
    always_ff @(posedge clk) begin
        if (capture) hold_data <= adc_data;
    end

endmodule

// File: rtl/sdadc_sample_arbiter.sv
// Merges NUM_CH sigma-delta ADC sample streams into one valid/ready stream
// using a round-robin arbiter feeding a single output register.
module sdadc_sample_arbiter
    import sdadc_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int ADC_BITLEN     = 16,
    parameter int SETTLE_SAMPLES = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              ch_enable,
    output logic [NUM_CH-1:0]              adc_rst,
    input  logic [NUM_CH*ADC_BITLEN-1:0]   adc_output,
    input  logic [NUM_CH-1:0]              adc_valid,
    output logic [ADC_BITLEN-1:0]          m_data,
    output logic [$clog2(NUM_CH)-1:0]      m_chan,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [NUM_CH-1:0]              overrun,
    input  logic                           overrun_clr
);

    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]     pending, req, grant;
    logic [ADC_BITLEN-1:0] hold_data [NUM_CH];
    logic [CH_W-1:0]       rr_ptr, grant_idx;
    logic                  grant_found, load;

    assign load = !m_valid || m_ready;
    // A channel being disabled this cycle must not leak its pending sample.
    assign req  = pending & ch_enable;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sdadc_ch_ctrl #(
            .ADC_BITLEN     (ADC_BITLEN),
            .SETTLE_SAMPLES (SETTLE_SAMPLES)
        ) u_ch_ctrl (
            .clk         (clk),
            .rst         (rst),
            .enable      (ch_enable[i]),
            .adc_valid   (adc_valid[i]),
            .adc_data    (adc_output[i*ADC_BITLEN +: ADC_BITLEN]),
            .grant       (grant[i]),
            .overrun_clr (overrun_clr),
            .adc_rst     (adc_rst[i]),
            .pending     (pending[i]),
            .hold_data   (hold_data[i]),
            .overrun     (overrun[i])
        );
    end

    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant       = '0;
        // Search starts one past the last-granted channel and wraps.
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (!grant_found && req[idx]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(idx);
            end
        end
        if (load && grant_found) grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_chan  <= '0;
            rr_ptr  <= CH_W'(NUM_CH - 1);
        end else if (load) begin
            m_valid <= grant_found;
            if (grant_found) begin
                m_data <= hold_data[grant_idx];
                m_chan <= grant_idx;
                rr_ptr <= grant_idx;
            end
        end
    end

endmodule

// File: doc/sdadc_sample_arbiter.md
SDADC_SAMPLE_ARBITER -- requirements
Module: sdadc_sample_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of sigma-delta ADC channels served (2..16).
REQ-002 SHALL have parameter ADC_BITLEN, default 16: sample width, equal to each ADC's output width.
REQ-003 SHALL have parameter SETTLE_SAMPLES, default 4: post-enable samples discarded per channel for CIC/DC-block settling (0..255).
REQ-004 SHALL have port clk, input, 1: single clock, shared with all ADC instances.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port ch_enable, input, NUM_CH: per-channel run request.
REQ-007 SHALL have port adc_rst, output, NUM_CH: drives each ADC's rst input.
REQ-008 SHALL have port adc_output, input, NUM_CH*ADC_BITLEN: flattened ADC samples, channel i at bits [i*ADC_BITLEN +: ADC_BITLEN].
REQ-009 SHALL have port adc_valid, input, NUM_CH: one-cycle sample strobe per channel.
REQ-010 SHALL have ports m_data (output, ADC_BITLEN), m_chan (output, $clog2(NUM_CH)), m_valid (output, 1), m_ready (input, 1): merged sample stream.
REQ-011 SHALL have ports overrun (output, NUM_CH, sticky per-channel loss flag) and overrun_clr (input, 1, clears all overrun bits).

Function
REQ-012 SHALL run one FSM per channel with states OFF, SETTLE, RUN.
REQ-013 SHALL assert adc_rst[i] exactly while channel i is in OFF, decoded from the state register (no combinational path from ch_enable).
REQ-014 SHALL move OFF->SETTLE when ch_enable[i]=1, clearing the settle counter; if SETTLE_SAMPLES=0, OFF->RUN directly.
REQ-015 SHALL in SETTLE count adc_valid[i] pulses, discard them, and move to RUN on the pulse that makes the count equal SETTLE_SAMPLES.
REQ-016 SHALL move any state->OFF on the cycle after ch_enable[i]=0, clearing that channel's pending flag; a sample already in the output register is still delivered.
REQ-017 SHALL in RUN capture adc_valid[i] samples into a one-deep holding register with pending flag; adc_valid outside RUN is ignored.
REQ-018 SHALL on adc_valid[i] with pending already set and not drained that cycle overwrite the holding register (newest wins) and set overrun[i].
REQ-019 SHALL on adc_valid[i] in the same cycle the pending sample is granted capture the new sample with no overrun.
REQ-020 SHALL load the output register when m_valid=0 or m_ready=1, granting round-robin among pending channels starting after the last-granted channel.
REQ-021 SHALL hold m_data, m_chan, m_valid stable while m_valid=1 and m_ready=0.
REQ-022 SHALL sustain one sample per cycle with m_ready held high; latency adc_valid -> m_valid is 2 cycles when uncontested.
REQ-023 SHALL clear overrun on overrun_clr; simultaneous set and clear leaves the bit set.

Reset
REQ-024 SHALL on rst: all channels OFF, adc_rst all ones, pending and settle counters zero, m_valid=0, m_data=0, m_chan=0, overrun=0, round-robin pointer NUM_CH-1 (channel 0 first).
REQ-025 SHALL apply rst asynchronously on assertion and release synchronously to clk; rst mid-transfer drops the in-flight sample.

Structure
REQ-026 SHALL place ch_state_t enum (OFF, SETTLE, RUN) and the settle counter width constant (8) in package sdadc_pkg.
REQ-027 SHALL implement per-channel FSM, settle counter, holding register, and overrun logic in sub-module sdadc_ch_ctrl, instanced NUM_CH times; arbiter and output register stay in the top.

Verification
REQ-028 SHALL cover settle: SETTLE_SAMPLES=4, enable ch0, 6 adc_valid pulses with data 1..6 -> only 5 and 6 appear, m_chan=0.
REQ-029 SHALL cover fairness: all 4 channels pulse adc_valid same cycle, m_ready=1 -> m_chan 0,1,2,3 on consecutive cycles, no overrun.
REQ-030 SHALL cover backpressure: m_ready=0 for 10 cycles, ch1 pulses 0xAAAA then 0x5555 -> output held stable; after release 0x5555 follows the held sample, overrun[1]=1.
REQ-031 SHALL cover disable: deassert ch_enable[2] with sample pending -> sample never emitted, adc_rst[2]=1 next cycle, re-enable re-enters SETTLE.
REQ-032 SHALL cover overrun_clr coinciding with a new overrun on ch3 -> overrun[3] stays 1; other bits clear.
REQ-033 SHALL cover async rst asserted mid-stream, no clock edge -> m_valid=0 and adc_rst all ones immediately.
